decode_stage_pipe: RTL and testbench

//  Parametrised Y86-64 pipeline decode stage with an owned register file. Selects source and

---
 rtl/y86_pkg.sv | 22 ++
 rtl/y86_regfile.sv | 53 +++++
 rtl/decode_stage_pipe.sv | 196 +++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and defaults for the decode stage and its register file.
package y86_pkg;

   localparam int unsigned DATA_W_DEF = 64;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] RNONE     = 4'hF;
   localparam logic [3:0] NOP_ICODE = I_NOP;

endpackage : y86_pkg

// File: rtl/y86_regfile.sv
// Architectural register file: two asynchronous read ports, two synchronous write ports (M wins).
module y86_regfile
   import y86_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned NREG   = 15,
   parameter int unsigned RID_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RID_W-1:0]  rd_a_id,
   input  logic [RID_W-1:0]  rd_b_id,
   output logic [DATA_W-1:0] rd_a_val_c,
   output logic [DATA_W-1:0] rd_b_val_c,
   input  logic [RID_W-1:0]  wr_e_id,
   input  logic [DATA_W-1:0] wr_e_val,
   input  logic [RID_W-1:0]  wr_m_id,
   input  logic [DATA_W-1:0] wr_m_val
);

   localparam logic [RID_W-1:0] RNONE_ID = RID_W'(RNONE);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];

   function automatic logic id_ok(input logic [RID_W-1:0] id);
      return (id != RNONE_ID) && (32'(id) < NREG);
   endfunction

   // Reads see the pre-edge contents; RNONE and out-of-range ids read as zero.
   always_comb begin
      rd_a_val_c = '0;
      rd_b_val_c = '0;
      if (id_ok(rd_a_id)) rd_a_val_c = regs_q[rd_a_id];
      if (id_ok(rd_b_id)) rd_b_val_c = regs_q[rd_b_id];
   end

   // Port M is applied last so it overrides port E on a shared destination.
   always_comb begin
      regs_d = regs_q;
      if (id_ok(wr_e_id)) regs_d[wr_e_id] = wr_e_val;
      if (id_ok(wr_m_id)) regs_d[wr_m_id] = wr_m_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule : y86_regfile

// File: rtl/decode_stage_pipe.sv
// Y86-64 decode stage: register selection, operand read with forwarding, and the D->E register.
module decode_stage_pipe
   import y86_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned NREG   = 15,
   parameter int unsigned RID_W  = 4,
   parameter int unsigned RSP_ID = 4,
   parameter bit          FWD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        D_icode,
   input  logic [3:0]        D_ifun,
   input  logic [RID_W-1:0]  D_rA,
   input  logic [RID_W-1:0]  D_rB,
   input  logic [DATA_W-1:0] D_valC,
   input  logic [DATA_W-1:0] D_valP,
   input  logic [RID_W-1:0]  e_dstE,
   input  logic [DATA_W-1:0] e_valE,
   input  logic [RID_W-1:0]  M_dstE,
   input  logic [DATA_W-1:0] M_valE,
   input  logic [RID_W-1:0]  m_dstM,
   input  logic [DATA_W-1:0] m_valM,
   input  logic [RID_W-1:0]  W_dstE,
   input  logic [DATA_W-1:0] W_valE,
   input  logic [RID_W-1:0]  W_dstM,
   input  logic [DATA_W-1:0] W_valM,
   input  logic              E_stall,
   input  logic              E_bubble,
   output logic [RID_W-1:0]  d_srcA,
   output logic [RID_W-1:0]  d_srcB,
   output logic [3:0]        E_icode,
   output logic [3:0]        E_ifun,
   output logic [DATA_W-1:0] E_valC,
   output logic [DATA_W-1:0] E_valA,
   output logic [DATA_W-1:0] E_valB,
   output logic [RID_W-1:0]  E_dstE,
   output logic [RID_W-1:0]  E_dstM,
   output logic [RID_W-1:0]  E_srcA,
   output logic [RID_W-1:0]  E_srcB
);

   localparam logic [RID_W-1:0] RNONE_ID = RID_W'(RNONE);
   localparam logic [RID_W-1:0] RSP      = RID_W'(RSP_ID);

   logic [RID_W-1:0]  src_a, src_b, dst_e, dst_m;
   logic              known;
   logic [DATA_W-1:0] rf_a, rf_b, fwd_a, fwd_b, val_a, val_b, val_c;

   // Register-id selection by instruction class.
   always_comb begin
      src_a = RNONE_ID;
      src_b = RNONE_ID;
      dst_e = RNONE_ID;
      dst_m = RNONE_ID;
      known = 1'b1;
      case (D_icode)
         I_HALT, I_NOP, I_JXX: ;
         I_RRMOVQ: begin src_a = D_rA; dst_e = D_rB; end
         I_IRMOVQ: dst_e = D_rB;
         I_RMMOVQ: begin src_a = D_rA; src_b = D_rB; end
         I_MRMOVQ: begin src_b = D_rB; dst_m = D_rA; end
         I_OPQ:    begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
         I_CALL:   begin src_b = RSP; dst_e = RSP; end
         I_RET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
         I_PUSHQ:  begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
         I_POPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = D_rA; end
         default:  known = 1'b0;
      endcase
   end

   assign d_srcA = src_a;
   assign d_srcB = src_b;

   y86_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG),
      .RID_W  (RID_W)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .rd_a_id    (src_a),
      .rd_b_id    (src_b),
      .rd_a_val_c (rf_a),
      .rd_b_val_c (rf_b),
      .wr_e_id    (W_dstE),
      .wr_e_val   (W_valE),
      .wr_m_id    (W_dstM),
      .wr_m_val   (W_valM)
   );

   // Youngest producer wins; an RNONE source never matches a stage destination.
   if (FWD_EN) begin : g_fwd
      always_comb begin
         fwd_a = rf_a;
         if (src_a == RNONE_ID)    fwd_a = '0;
         else if (src_a == e_dstE) fwd_a = e_valE;
         else if (src_a == m_dstM) fwd_a = m_valM;
         else if (src_a == M_dstE) fwd_a = M_valE;
         else if (src_a == W_dstM) fwd_a = W_valM;
         else if (src_a == W_dstE) fwd_a = W_valE;

         fwd_b = rf_b;
         if (src_b == RNONE_ID)    fwd_b = '0;
         else if (src_b == e_dstE) fwd_b = e_valE;
         else if (src_b == m_dstM) fwd_b = m_valM;
         else if (src_b == M_dstE) fwd_b = M_valE;
         else if (src_b == W_dstM) fwd_b = W_valM;
         else if (src_b == W_dstE) fwd_b = W_valE;
      end
   end else begin : g_nofwd
      assign fwd_a = rf_a;
      assign fwd_b = rf_b;
   end

   always_comb begin
      val_a = fwd_a;
      if ((D_icode == I_CALL) || (D_icode == I_JXX)) val_a = D_valP;
      val_b = fwd_b;
      val_c = known ? D_valC : '0;
   end

   logic [3:0]        icode_q, icode_d, ifun_q, ifun_d;
   logic [DATA_W-1:0] valc_q, valc_d, vala_q, vala_d, valb_q, valb_d;
   logic [RID_W-1:0]  dste_q, dste_d, dstm_q, dstm_d, srca_q, srca_d, srcb_q, srcb_d;

   // E register next state: bubble over stall over load.
   always_comb begin
      icode_d = icode_q;
      ifun_d  = ifun_q;
      valc_d  = valc_q;
      vala_d  = vala_q;
      valb_d  = valb_q;
      dste_d  = dste_q;
      dstm_d  = dstm_q;
      srca_d  = srca_q;
      srcb_d  = srcb_q;
      if (E_bubble) begin
         icode_d = NOP_ICODE;
         ifun_d  = '0;
         valc_d  = '0;
         vala_d  = '0;
         valb_d  = '0;
         dste_d  = RNONE_ID;
         dstm_d  = RNONE_ID;
         srca_d  = RNONE_ID;
         srcb_d  = RNONE_ID;
      end else if (!E_stall) begin
         icode_d = D_icode;
         ifun_d  = D_ifun;
         valc_d  = val_c;
         vala_d  = val_a;
         valb_d  = val_b;
         dste_d  = dst_e;
         dstm_d  = dst_m;
         srca_d  = src_a;
         srcb_d  = src_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         icode_q <= NOP_ICODE;
         ifun_q  <= '0;
         valc_q  <= '0;
         vala_q  <= '0;
         valb_q  <= '0;
         dste_q  <= RNONE_ID;
         dstm_q  <= RNONE_ID;
         srca_q  <= RNONE_ID;
         srcb_q  <= RNONE_ID;
      end else begin
         icode_q <= icode_d;
         ifun_q  <= ifun_d;
         valc_q  <= valc_d;
         vala_q  <= vala_d;
         valb_q  <= valb_d;
         dste_q  <= dste_d;
         dstm_q  <= dstm_d;
         srca_q  <= srca_d;
         srcb_q  <= srcb_d;
      end
   end

   assign E_icode = icode_q;
   assign E_ifun  = ifun_q;
   assign E_valC  = valc_q;
   assign E_valA  = vala_q;
   assign E_valB  = valb_q;
   assign E_dstE  = dste_q;
   assign E_dstM  = dstm_q;
   assign E_srcA  = srca_q;
   assign E_srcB  = srcb_q;

endmodule : decode_stage_pipe

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: a forwarding build and a regfile-only build side by side.
module tb_decode_stage_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
   logic [63:0] D_valC, D_valP;
   logic [3:0]  e_dstE, M_dstE, m_dstM, W_dstE, W_dstM;
   logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
   logic        E_stall, E_bubble;

   logic [3:0]  f_srcA, f_srcB, f_icode, f_ifun, f_dstE, f_dstM, f_esrcA, f_esrcB;
   logic [63:0] f_valC, f_valA, f_valB;
   logic [3:0]  n_srcA, n_srcB, n_icode, n_ifun, n_dstE, n_dstM, n_esrcA, n_esrcB;
   logic [63:0] n_valC, n_valA, n_valB;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decode_stage_pipe #(.FWD_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
      .D_valC(D_valC), .D_valP(D_valP), .e_dstE(e_dstE), .e_valE(e_valE),
      .M_dstE(M_dstE), .M_valE(M_valE), .m_dstM(m_dstM), .m_valM(m_valM),
      .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
      .E_stall(E_stall), .E_bubble(E_bubble), .d_srcA(f_srcA), .d_srcB(f_srcB),
      .E_icode(f_icode), .E_ifun(f_ifun), .E_valC(f_valC), .E_valA(f_valA), .E_valB(f_valB),
      .E_dstE(f_dstE), .E_dstM(f_dstM), .E_srcA(f_esrcA), .E_srcB(f_esrcB)
   );

   decode_stage_pipe #(.FWD_EN(1'b0)) u_nofwd (
      .clk(clk), .rst(rst), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
      .D_valC(D_valC), .D_valP(D_valP), .e_dstE(e_dstE), .e_valE(e_valE),
      .M_dstE(M_dstE), .M_valE(M_valE), .m_dstM(m_dstM), .m_valM(m_valM),
      .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
      .E_stall(E_stall), .E_bubble(E_bubble), .d_srcA(n_srcA), .d_srcB(n_srcB),
      .E_icode(n_icode), .E_ifun(n_ifun), .E_valC(n_valC), .E_valA(n_valA), .E_valB(n_valB),
      .E_dstE(n_dstE), .E_dstM(n_dstM), .E_srcA(n_esrcA), .E_srcB(n_esrcB)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic decode(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
      D_icode = ic; D_ifun = fn; D_rA = ra; D_rB = rb; D_valC = vc; D_valP = vp;
   endtask

   task automatic clear_fwd();
      e_dstE = 4'hF; M_dstE = 4'hF; m_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
      e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
   endtask

   initial begin
      rst = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
      decode(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
      clear_fwd();

      // Reset
      step(); step();
      chk("rst_icode", 64'(f_icode), 64'h1);
      chk("rst_ifun", 64'(f_ifun), 64'h0);
      chk("rst_dstE", 64'(f_dstE), 64'hF);
      chk("rst_dstM", 64'(f_dstM), 64'hF);
      chk("rst_valA", f_valA, 64'h0);
      chk("rst_valB", f_valB, 64'h0);
      chk("rst_nf_icode", 64'(n_icode), 64'h1);
      rst = 1'b0;

      // Regfile write then plain read
      W_dstE = 4'd3; W_valE = 64'h55;
      step();
      clear_fwd();
      decode(4'h6, 4'h2, 4'd3, 4'd3, 64'h0, 64'h0);
      #1;
      chk("opq_srcA_c", 64'(f_srcA), 64'd3);
      chk("opq_srcB_c", 64'(f_srcB), 64'd3);
      step();
      chk("opq_valA", f_valA, 64'h55);
      chk("opq_valB", f_valB, 64'h55);
      chk("opq_icode", 64'(f_icode), 64'h6);
      chk("opq_ifun", 64'(f_ifun), 64'h2);
      chk("opq_dstE", 64'(f_dstE), 64'd3);
      chk("opq_nf_valA", n_valA, 64'h55);

      // Unwritten registers read zero
      decode(4'h6, 4'h0, 4'd0, 4'd14, 64'h0, 64'h0);
      step();
      chk("rf0_valA", f_valA, 64'h0);
      chk("rf14_valB", f_valB, 64'h0);

      // Forwarding priority on register 2
      decode(4'h6, 4'h0, 4'd2, 4'd1, 64'h0, 64'h0);
      e_dstE = 4'd2; e_valE = 64'h11;
      M_dstE = 4'd2; M_valE = 64'h22;
      W_dstE = 4'd2; W_valE = 64'h33;
      step();
      chk("fwd_e_valA", f_valA, 64'h11);
      chk("fwd_e_valB", f_valB, 64'h0);
      chk("nofwd_old_valA", n_valA, 64'h0);
      e_dstE = 4'hF;
      step();
      chk("fwd_M_valA", f_valA, 64'h22);
      chk("nofwd_rf_valA", n_valA, 64'h33);
      m_dstM = 4'd2; m_valM = 64'h44;
      step();
      chk("fwd_m_valA", f_valA, 64'h44);
      m_dstM = 4'hF; M_dstE = 4'hF;
      W_dstM = 4'd2; W_valM = 64'h66;
      step();
      chk("fwd_WM_valA", f_valA, 64'h66);
      chk("nofwd_pre_valA", n_valA, 64'h33);
      clear_fwd();
      step();
      chk("rf_mwins_valA", f_valA, 64'h66);
      chk("rf_mwins_nf_valA", n_valA, 64'h66);

      // Same-register dual write, then POPQ reads it
      decode(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
      W_dstE = 4'd4; W_valE = 64'h100;
      W_dstM = 4'd4; W_valM = 64'h200;
      step();
      clear_fwd();
      decode(4'hB, 4'h0, 4'd5, 4'hF, 64'h0, 64'h0);
      #1;
      chk("pop_srcA_c", 64'(f_srcA), 64'd4);
      chk("pop_srcB_c", 64'(f_srcB), 64'd4);
      step();
      chk("pop_valA", f_valA, 64'h200);
      chk("pop_valB", f_valB, 64'h200);
      chk("pop_dstE", 64'(f_dstE), 64'd4);
      chk("pop_dstM", 64'(f_dstM), 64'd5);

      // CALL uses valP for valA and rsp for valB
      decode(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
      W_dstE = 4'd4; W_valE = 64'h80;
      step();
      clear_fwd();
      decode(4'h8, 4'h0, 4'hF, 4'hF, 64'h1234, 64'h40);
      step();
      chk("call_valA", f_valA, 64'h40);
      chk("call_valB", f_valB, 64'h80);
      chk("call_dstE", 64'(f_dstE), 64'd4);
      chk("call_dstM", 64'(f_dstM), 64'hF);
      chk("call_valC", f_valC, 64'h1234);
      chk("call_srcA", 64'(f_esrcA), 64'hF);
      chk("call_srcB", 64'(f_esrcB), 64'd4);
      chk("call_nf_valA", n_valA, 64'h40);

      // Stall holds E while D changes
      E_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         decode(4'h6, 4'(i), 4'd3, 4'd3, 64'(i), 64'h0);
         step();
         chk("stall_icode", 64'(f_icode), 64'h8);
         chk("stall_valA", f_valA, 64'h40);
         chk("stall_dstE", 64'(f_dstE), 64'd4);
      end

      // Bubble beats stall
      E_bubble = 1'b1;
      step();
      chk("bub_icode", 64'(f_icode), 64'h1);
      chk("bub_ifun", 64'(f_ifun), 64'h0);
      chk("bub_valA", f_valA, 64'h0);
      chk("bub_valB", f_valB, 64'h0);
      chk("bub_valC", f_valC, 64'h0);
      chk("bub_dstE", 64'(f_dstE), 64'hF);
      chk("bub_srcB", 64'(f_esrcB), 64'hF);
      E_bubble = 1'b0; E_stall = 1'b0;

      // IRMOVQ after release
      decode(4'h3, 4'h0, 4'hF, 4'd7, 64'h99, 64'h0);
      step();
      chk("irmov_icode", 64'(f_icode), 64'h3);
      chk("irmov_dstE", 64'(f_dstE), 64'd7);
      chk("irmov_valC", f_valC, 64'h99);
      chk("irmov_srcA", 64'(f_esrcA), 64'hF);

      // RNONE source never takes a forward even when a stage dst is RNONE
      decode(4'h6, 4'h0, 4'hF, 4'd0, 64'h0, 64'h0);
      e_valE = 64'hDEAD;
      step();
      chk("rnone_valA", f_valA, 64'h0);
      clear_fwd();

      // Unknown icode
      decode(4'hC, 4'h0, 4'd3, 4'd3, 64'h77, 64'h0);
      #1;
      chk("unk_srcA_c", 64'(f_srcA), 64'hF);
      step();
      chk("unk_valC", f_valC, 64'h0);
      chk("unk_valB", f_valB, 64'h0);
      chk("unk_dstE", 64'(f_dstE), 64'hF);
      chk("unk_srcB", 64'(f_esrcB), 64'hF);

      // Mid-stream reset discards E and clears the regfile
      decode(4'h6, 4'h0, 4'd2, 4'd3, 64'h0, 64'h0);
      rst = 1'b1;
      step();
      chk("mrst_icode", 64'(f_icode), 64'h1);
      chk("mrst_valA", f_valA, 64'h0);
      rst = 1'b0;
      step();
      chk("mrst_load_icode", 64'(f_icode), 64'h6);
      chk("mrst_rf2", f_valA, 64'h0);
      chk("mrst_rf3", f_valB, 64'h0);
      chk("mrst_nf_rf2", n_valA, 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_decode_stage_pipe
